// File: rtl/multi_click_pkg.sv
// multi_click_pkg: state encoding shared by the multi-click decoder.
package multi_click_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, REPORT} mc_state_t;
endpackage

// File: rtl/gap_timer.sv
// gap_timer: counts idle cycles and flags when the gap reaches WINDOW-1; saturates there.
module gap_timer #(
    parameter int WINDOW = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);
    localparam int TW = $clog2(WINDOW);
    localparam logic [TW-1:0] LAST = TW'(WINDOW - 1);
    logic [TW-1:0] count;
    always_ff @(posedge clk) begin
        if (!rst || clear) count <= '0;
        else if (run && !expire) count <= count + 1'b1;
    end
    assign expire = count == LAST;
endmodule

// File: rtl/multi_click_decoder.sv
// multi_click_decoder: groups debounced press pulses into bursts and reports the burst size.
module multi_click_decoder
    import multi_click_pkg::*;
#(
    parameter int WINDOW     = 25_000_000,
    parameter int MAX_CLICKS = 3,
    parameter int CW         = $clog2(MAX_CLICKS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          press,
    output logic          click_valid,
    output logic [CW-1:0] click_count,
    output logic          busy
);
    localparam logic [CW-1:0] MAXC = CW'(MAX_CLICKS);
    localparam logic [CW-1:0] ONE  = CW'(1);
    mc_state_t     state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          expire;
    assign cnt_inc = cnt + 1'b1;
    // the timer restarts on every press so the window is measured from the latest one
    gap_timer #(.WINDOW(WINDOW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (press || state != COLLECT),
        .run    (state == COLLECT),
        .expire (expire)
    );
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            click_valid <= 1'b0;
            click_count <= '0;
            busy        <= 1'b0;
        end else begin
            click_valid <= 1'b0;
            busy        <= 1'b1;
            case (state)
                IDLE, REPORT: begin
                    if (press) begin
                        cnt         <= ONE;
                        state       <= (ONE == MAXC) ? REPORT : COLLECT;
                        click_valid <= ONE == MAXC;
                        click_count <= (ONE == MAXC) ? ONE : click_count;
                    end else begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (press) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == MAXC) begin
                            state       <= REPORT;
                            click_valid <= 1'b1;
                            click_count <= cnt_inc;
                        end
                    end else if (expire) begin
                        state       <= REPORT;
                        click_valid <= 1'b1;
                        click_count <= cnt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_click_decoder.sv
// tb_multi_click_decoder: directed bursts checked against a gap-counting model and literal expectations.
module tb_multi_click_decoder;
    localparam int WINDOW     = 8;
    localparam int MAX_CLICKS = 3;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       press = 1'b0;
    logic       click_valid;
    logic       busy;
    logic [1:0] click_count;
    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int m_n = 0;
    int m_gap = 0;
    logic       ev = 1'b0;
    logic       eb = 1'b0;
    logic [1:0] ec = 2'd0;

    always #5 clk = ~clk;

    multi_click_decoder #(.WINDOW(WINDOW), .MAX_CLICKS(MAX_CLICKS)) dut (
        .clk         (clk),
        .rst         (rst),
        .press       (press),
        .click_valid (click_valid),
        .click_count (click_count),
        .busy        (busy)
    );

    // model: a burst ends when it holds MAX_CLICKS presses or when WINDOW quiet cycles follow its last press
    always @(posedge clk) begin
        if (!rst) begin
            m_n = 0;
            m_gap = 0;
            ev = 1'b0;
            ec = 2'd0;
            eb = 1'b0;
        end else begin
            if (press) begin
                m_n++;
                m_gap = 0;
            end else if (m_n > 0) m_gap++;
            if (m_n == MAX_CLICKS || (m_n > 0 && m_gap == WINDOW)) begin
                ev = 1'b1;
                ec = 2'(m_n);
                m_n = 0;
                m_gap = 0;
            end else ev = 1'b0;
            eb = (m_n > 0) || ev;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    function automatic logic [63:0] b(input int i);
        return 64'd1 << i;
    endfunction

    task automatic scn(input logic [63:0] pm, input logic [63:0] rm, input logic [63:0] vm,
                       input int lc, input int zc);
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            cyc = c;
            if (c > 0) begin
                chk("model_valid", click_valid, ev);
                chk("model_count", click_count, ec);
                chk("model_busy", busy, eb);
            end
            if (c >= 5) chk("lit_valid", click_valid, vm[c]);
            if (vm[c]) chk("lit_count", click_count, lc);
            if (zc > 0 && c >= zc) begin
                chk("lit_zero_count", click_count, 0);
                chk("lit_idle_busy", busy, 0);
            end
            rst = !rm[c];
            press = pm[c];
        end
    endtask

    initial begin
        scn(b(10), 64'hF, b(19), 1, 0);
        scn(b(10) | b(15), 64'hF, b(24), 2, 0);
        scn(b(10) | b(12) | b(14), 64'hF, b(15), 3, 0);
        scn(b(10) | b(18), 64'hF, b(27), 2, 0);
        scn(b(10) | b(19), 64'hF, b(19) | b(28), 1, 0);
        scn(b(10), 64'hF | b(13) | b(14), 64'd0, 0, 14);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/multi_click_decoder.md
Name: multi_click_decoder

Overview:
- Sits directly downstream of the button debouncer. It consumes that block's one-cycle press pulse, which marks the debounced rising edge.
- Groups presses separated by less than a programmable gap window into one "click burst".
- Reports the burst size (single, double, triple, ...) as a one-cycle valid strobe with a count, for UI/mode-select logic.
- Runs entirely in the fast system clock domain, the same domain as the debouncer's output pulse.

Parameters:
- WINDOW, 25_000_000, maximum gap in clk cycles between presses of one burst; legal range >= 2.
- MAX_CLICKS, 3, burst size at which the block reports immediately without waiting for the window; legal range >= 1.
- CW, $clog2(MAX_CLICKS+1), width of click_count (derived, not overridden).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-low; sampled only on rising clk.
- press  input  1  single-cycle press pulse from the debouncer; back-to-back high cycles count as separate presses.
- click_valid  output  1  one-cycle strobe: a burst has ended.
- click_count  output  CW  number of presses in the reported burst; valid with click_valid, held until the next report.
- busy  output  1  high while a burst is being collected or reported (state != IDLE).

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, press count=0, gap timer=0.
  - click_valid=0, click_count=0, busy=0.
  - A burst in progress is discarded and no report is issued.
- States: IDLE, COLLECT, REPORT. All outputs are registered.
- IDLE:
  - press=1 -> COLLECT with cnt=1 and timer=0.
  - If MAX_CLICKS==1, the transition goes to REPORT instead.
- COLLECT:
  - Each cycle without a press, timer increments.
  - press=1 -> cnt=cnt+1, timer=0. If the new cnt==MAX_CLICKS -> REPORT.
  - timer==WINDOW-1 with press=0 -> REPORT.
  - If press=1 in the cycle where timer==WINDOW-1, the press wins: it is counted and the timer restarts.
- REPORT (exactly one cycle):
  - click_valid=1 and click_count=cnt.
  - Next state is IDLE.
  - press=1 during REPORT starts a new burst: next state COLLECT with cnt=1 (REPORT if MAX_CLICKS==1). The press is never dropped.
- Latency:
  - Last press sampled in cycle t with no further presses -> click_valid in cycle t+WINDOW+1.
  - Press that brings cnt to MAX_CLICKS, sampled in cycle t -> click_valid in cycle t+1.
- Width rules:
  - Timer width is $clog2(WINDOW).
  - cnt never exceeds MAX_CLICKS, so no wrap is possible.
  - The timer never passes WINDOW-1.
- busy is 1 in COLLECT and REPORT and 0 in IDLE. It is 0 in the cycle after REPORT unless a new burst started.
- click_valid is never high on two consecutive cycles.

Decomposition:
- Package multi_click_pkg:
  - typedef enum logic [1:0] {IDLE, COLLECT, REPORT} mc_state_t.
  - No other shared constants.
- Sub-module gap_timer:
  - Inputs: clk, rst, clear, run.
  - Output: expire, asserted when the count == WINDOW-1.
  - Parameterised on WINDOW.
  - Natural to split out for reuse by the planned long-press detector.
- FSM and counters stay in the top module.

Test Plan (WINDOW=8, MAX_CLICKS=3, reset released before cycle 5):
- Single press at cycle 10 -> click_valid=1 only in cycle 19, click_count=1; busy=1 in cycles 11-19, 0 at 20.
- Presses at cycles 10 and 15 -> one click_valid in cycle 24 with click_count=2; none earlier.
- Presses at cycles 10, 12, 14 -> click_valid in cycle 15, click_count=3 (MAX early report); busy=0 at 16.
- Boundary press: presses at 10 and 18 (timer==7 at 18) -> counted as one burst; click_valid in 27, click_count=2.
- Press during REPORT: press at 10, valid at 19, press also at 19 -> second click_valid at 28 with click_count=1; click_count holds 1 between reports.
- Reset mid-burst: press at 10, rst=0 in cycles 13-14 -> no click_valid through cycle 40; busy=0 and click_count=0 from cycle 14.
